rk4_linear_solver: RTL

//  Parametrised, handshake-driven fixed-point RK4 integrator for dy/dx = A*x + B*y + C.

---
 rtl/rk4_linear_solver.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/rk4_linear_solver.sv
// Fixed-point RK4 integrator for dy/dx = A*x + B*y + C with run-time operands, start/busy/done handshake and abort.
// DONE arrives 1+5*N_STEPS cycles after an accepted START; one shared datapath evaluates K1..K4, then the update.
module rk4_linear_solver #(
  parameter int W    = 32,
  parameter int FRAC = 16,
  parameter int NW   = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic [W-1:0]  X0,
  input  logic [W-1:0]  Y0,
  input  logic [W-1:0]  H,
  input  logic [W-1:0]  COEF_A,
  input  logic [W-1:0]  COEF_B,
  input  logic [W-1:0]  COEF_C,
  input  logic [NW-1:0] N_STEPS,
  output logic          BUSY,
  output logic          DONE,
  output logic [W-1:0]  X_OUT,
  output logic [W-1:0]  Y_OUT,
  output logic [NW-1:0] STEP_CNT,
  output logic          OVF
);
  localparam int XW = 2*W + 3;
  localparam logic signed [XW-1:0] MAXV = {{(XW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(XW-W+1){1'b1}}, {(W-1){1'b0}}};
  localparam longint SIXTH_L = ((longint'(1) <<< FRAC) + 3) / 6;
  localparam logic signed [XW-1:0] SIXTH = XW'(SIXTH_L);

  typedef enum logic [2:0] {S_IDLE, S_K1, S_K2, S_K3, S_K4, S_UPD, S_FIN} state_t;

  // All intermediate results are carried in XW bits so one clamp covers every op.
  function automatic logic signed [W-1:0] f_sat(input logic signed [XW-1:0] v);
    if (v > MAXV) return MAXV[W-1:0];
    if (v < MINV) return MINV[W-1:0];
    return v[W-1:0];
  endfunction

  function automatic logic f_over(input logic signed [XW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [XW-1:0] f_mulx(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    logic signed [2*W-1:0] p;
    p = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    p = p >>> FRAC;
    return $signed({{(XW-2*W){p[2*W-1]}}, p});
  endfunction

  function automatic logic signed [XW-1:0] f_addx(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
    logic signed [W:0] s;
    s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    return $signed({{(XW-W-1){s[W]}}, s});
  endfunction

  state_t                r_state, w_next;
  logic signed [W-1:0]   r_x, r_y, r_h, r_a, r_b, r_c, r_k1, r_k2, r_k3, r_k4;
  logic [NW-1:0]         r_n, r_step, w_step_inc;
  logic [W-1:0]          r_x_out, r_y_out;
  logic                  r_ovf;

  logic signed [XW-1:0]  w_xhalf_e, w_xfull_e, w_yoff_e, w_ax_e, w_by_e, w_s1_e, w_f_e, w_k_e;
  logic signed [XW-1:0]  w_dy_e, w_ynew_e;
  logic signed [W-1:0]   w_xfull, w_yoffb, w_xa, w_ya, w_k, w_dy, w_ynew;
  logic signed [W+2:0]   w_ksum;
  logic                  w_ovf_arg, w_ovf_k, w_ovf_u;

  always_comb begin
    w_xhalf_e = f_addx(r_x, r_h >>> 1);
    w_xfull_e = f_addx(r_x, r_h);
    w_xfull   = f_sat(w_xfull_e);
    w_yoffb   = '0;
    case (r_state)
      S_K2:    w_yoffb = r_k1 >>> 1;
      S_K3:    w_yoffb = r_k2 >>> 1;
      S_K4:    w_yoffb = r_k3;
      default: ;
    endcase
    w_yoff_e  = f_addx(r_y, w_yoffb);
    w_xa      = r_x;
    w_ya      = r_y;
    w_ovf_arg = 1'b0;
    case (r_state)
      S_K2, S_K3: begin
        w_xa      = f_sat(w_xhalf_e);
        w_ya      = f_sat(w_yoff_e);
        w_ovf_arg = f_over(w_xhalf_e) | f_over(w_yoff_e);
      end
      S_K4: begin
        w_xa      = w_xfull;
        w_ya      = f_sat(w_yoff_e);
        w_ovf_arg = f_over(w_xfull_e) | f_over(w_yoff_e);
      end
      default: ;
    endcase
    w_ax_e  = f_mulx(r_a, w_xa);
    w_by_e  = f_mulx(r_b, w_ya);
    w_s1_e  = f_addx(f_sat(w_ax_e), f_sat(w_by_e));
    w_f_e   = f_addx(f_sat(w_s1_e), r_c);
    w_k_e   = f_mulx(r_h, f_sat(w_f_e));
    w_k     = f_sat(w_k_e);
    w_ovf_k = w_ovf_arg | f_over(w_ax_e) | f_over(w_by_e) | f_over(w_s1_e)
            | f_over(w_f_e) | f_over(w_k_e);
    // Weighted k-sum cannot exceed 6*2^(W-1), so W+3 bits never wrap.
    w_ksum  = {{3{r_k1[W-1]}}, r_k1} + ({{3{r_k2[W-1]}}, r_k2} << 1)
            + ({{3{r_k3[W-1]}}, r_k3} << 1) + {{3{r_k4[W-1]}}, r_k4};
    w_dy_e  = ($signed({{(XW-W-3){w_ksum[W+2]}}, w_ksum}) * SIXTH) >>> FRAC;
    w_dy    = f_sat(w_dy_e);
    w_ynew_e = f_addx(r_y, w_dy);
    w_ynew  = f_sat(w_ynew_e);
    w_ovf_u = f_over(w_dy_e) | f_over(w_ynew_e) | f_over(w_xfull_e);
    w_step_inc = r_step + NW'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (START && !ABORT) w_next = (N_STEPS == '0) ? S_FIN : S_K1;
      S_K1:    w_next = S_K2;
      S_K2:    w_next = S_K3;
      S_K3:    w_next = S_K4;
      S_K4:    w_next = S_UPD;
      S_UPD:   w_next = (w_step_inc == r_n) ? S_FIN : S_K1;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (ABORT && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      {r_x, r_y, r_h, r_a, r_b, r_c} <= '0;
      {r_k1, r_k2, r_k3, r_k4}       <= '0;
      r_n     <= '0;
      r_step  <= '0;
      r_x_out <= '0;
      r_y_out <= '0;
      r_ovf   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (START && !ABORT) begin
        r_x    <= X0;
        r_y    <= Y0;
        r_h    <= H;
        r_a    <= COEF_A;
        r_b    <= COEF_B;
        r_c    <= COEF_C;
        r_n    <= N_STEPS;
        r_step <= '0;
        r_ovf  <= 1'b0;
        if (N_STEPS == '0) begin
          r_x_out <= X0;
          r_y_out <= Y0;
        end
      end
    end else if (!ABORT) begin
      case (r_state)
        S_K1: r_k1 <= w_k;
        S_K2: r_k2 <= w_k;
        S_K3: r_k3 <= w_k;
        S_K4: r_k4 <= w_k;
        S_UPD: begin
          r_x    <= w_xfull;
          r_y    <= w_ynew;
          r_step <= w_step_inc;
          if (w_step_inc == r_n) begin
            r_x_out <= w_xfull;
            r_y_out <= w_ynew;
          end
        end
        default: ;
      endcase
      if (r_state inside {S_K1, S_K2, S_K3, S_K4}) r_ovf <= r_ovf | w_ovf_k;
      else if (r_state == S_UPD)                     r_ovf <= r_ovf | w_ovf_u;
    end
  end

  assign BUSY     = (r_state != S_IDLE) && (r_state != S_FIN);
  assign DONE     = (r_state == S_FIN);
  assign X_OUT    = r_x_out;
  assign Y_OUT    = r_y_out;
  assign STEP_CNT = r_step;
  assign OVF      = r_ovf;
endmodule
